// File: rtl/softmax_pkg.sv
// rtl/softmax_pkg.sv - shared constants, state enum and table helpers for softmax_stream
package softmax_pkg;

    // Q4.7 clip point for d = max - x (16.0) and ln(2) in Q7
    localparam logic [11:0] D_CLIP = 12'd2048;
    localparam int          LN2_Q7 = 89;

    // exp(-1/128) in Q30, from the Taylor series 1 - y + y^2/2 - y^3/6 with y = 2^-7
    localparam longint unsigned EXP_STEP_Q30 = 64'd1065385899;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EXP_ACC,
        ST_LN_SUM,
        ST_NORM
    } state_e;

    // round(128 * ln(1 + m/16)), m = 0..15
    localparam logic [6:0] LN1P_Q7 [16] = '{
        7'd0,  7'd8,  7'd15, 7'd22, 7'd29, 7'd35, 7'd41, 7'd46,
        7'd52, 7'd57, 7'd62, 7'd67, 7'd72, 7'd76, 7'd80, 7'd85
    };

    // exp(-a/128) in Q1.15, built by square-and-multiply of EXP_STEP_Q30; elaboration-time only
    function automatic int exp_q15(input int a);
        longint unsigned r;
        longint unsigned b;
        r = 64'd1 << 30;
        b = EXP_STEP_Q30;
        for (int i = 0; i < 12; i++) begin
            if (a[i]) r = (r * b + (64'd1 << 29)) >> 30;
            b = (b * b + (64'd1 << 29)) >> 30;
        end
        return int'((r + (64'd1 << 14)) >> 15);
    endfunction

endpackage

// File: rtl/softmax_stream_exp_lut.sv
// rtl/softmax_stream_exp_lut.sv - bipartite exp(-d) table pair with registered read
module exp_bipartite_lut
    import softmax_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic [10:0] d_i,
    input  logic        zero_i,
    output logic [15:0] exp_o
);

    // Coarse table holds exp at d = 8n; fine table holds the offset from the
    // middle of each 0.5-wide segment, so d = 0 reproduces 32768 exactly.
    logic [15:0] rom0 [256];
    logic [15:0] rom1 [256];

    for (genvar i = 0; i < 256; i++) begin : g_rom
        localparam int E0 = exp_q15(8 * i);
        localparam int E1 = exp_q15(64 * (i / 8) + 32 + (i % 8)) - exp_q15(64 * (i / 8) + 32);
        assign rom0[i] = E0[15:0];
        assign rom1[i] = E1[15:0];
    end

    logic [15:0]        lut0_q;
    logic [15:0]        lut1_q;
    logic               zero_q;
    logic signed [17:0] sum_w;

    // Table read stage; a low enable freezes both tables and the zero flag together
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lut0_q <= '0;
            lut1_q <= '0;
            zero_q <= 1'b0;
        end else if (en_i) begin
            lut0_q <= rom0[d_i[10:3]];
            lut1_q <= rom1[{d_i[10:6], d_i[2:0]}];
            zero_q <= zero_i;
        end
    end

    // Combine coarse + signed fine term, force zero, saturate at 1.0
    always_comb begin
        sum_w = $signed({2'b00, lut0_q}) + $signed({{2{lut1_q[15]}}, lut1_q});
        if (zero_q || sum_w < 0) begin
            exp_o = '0;
        end else if (sum_w > 18'sd32768) begin
            exp_o = 16'h8000;
        end else begin
            exp_o = sum_w[15:0];
        end
    end

endmodule

// File: rtl/softmax_stream.sv
// rtl/softmax_stream.sv - streaming safe-softmax row engine with masking and backpressure
module softmax_stream
    import softmax_pkg::*;
#(
    parameter int N_MAX = 256,
    parameter int IN_W  = 16,
    parameter int OUT_W = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic [$clog2(N_MAX):0]   len_i,
    input  logic                     in_valid_i,
    input  logic [IN_W-1:0]          in_data_i,
    input  logic                     in_mask_i,
    output logic                     in_ready_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [OUT_W-1:0]         out_data_o,
    output logic                     out_last_o,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam int AW    = $clog2(N_MAX);
    localparam int LEN_W = AW + 1;
    localparam int SUM_W = 16 + AW;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(N_MAX);

    state_e                 state_q, state_d;
    logic [LEN_W-1:0]       len_q, cnt_q;
    logic signed [IN_W-1:0] max_q;
    logic [SUM_W-1:0]       sum_q;
    logic [11:0]            ln_off_q, ln_off_d;
    logic                   v1_q, last1_q, v2_q, last2_q, done_q;

    logic [IN_W:0]          buf_mem [N_MAX];
    logic [IN_W:0]          buf_q;

    logic                   start_ok, wr_en, stall, adv, issue, out_hs;
    logic [IN_W:0]          diff;
    logic [11:0]            dclip;
    logic [12:0]            dd;
    logic                   zero_w;
    logic [15:0]            exp_w;
    int                     lead, ln_raw;
    logic [3:0]             mant;

    assign start_ok    = start_i && (len_i != '0) && (len_i <= LEN_MAX);
    assign wr_en       = (state_q == ST_LOAD) && in_valid_i;
    assign stall       = (state_q == ST_NORM) && v2_q && !out_ready_i;
    assign adv         = !stall;
    assign issue       = ((state_q == ST_EXP_ACC) || (state_q == ST_NORM)) && adv && (cnt_q < len_q);
    assign out_hs      = (state_q == ST_NORM) && v2_q && out_ready_i;

    assign in_ready_o  = (state_q == ST_LOAD);
    assign busy_o      = (state_q != ST_IDLE);
    assign out_valid_o = (state_q == ST_NORM) && v2_q;
    assign out_last_o  = out_valid_o && last2_q;
    assign out_data_o  = out_valid_o ? OUT_W'(exp_w) : '0;
    assign done_o      = done_q;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next-state: phases advance on the last load beat and on the last pipeline beat
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start_ok) state_d = ST_LOAD;
            ST_LOAD:    if (wr_en && (cnt_q + 1'b1 == len_q)) state_d = ST_EXP_ACC;
            ST_EXP_ACC: if (v2_q && last2_q) state_d = ST_LN_SUM;
            ST_LN_SUM:  state_d = ST_NORM;
            ST_NORM:    if (out_hs && last2_q) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Row buffer: written during LOAD, one registered read per issue slot
    always_ff @(posedge clk_i) begin
        if (wr_en) buf_mem[cnt_q[AW-1:0]] <= {in_mask_i, in_data_i};
        if (issue) buf_q <= buf_mem[cnt_q[AW-1:0]];
    end

    // d = max - x clipped to 16.0, plus the log-sum offset during NORM
    always_comb begin
        diff   = {max_q[IN_W-1], max_q} - {buf_q[IN_W-1], buf_q[IN_W-1:0]};
        dclip  = (diff >= (IN_W+1)'(D_CLIP)) ? D_CLIP : diff[11:0];
        dd     = {1'b0, dclip} + ((state_q == ST_NORM) ? {1'b0, ln_off_q} : 13'd0);
        zero_w = buf_q[IN_W] || diff[IN_W] || (dd >= 13'(D_CLIP));
    end

    // ln(sum) from the leading-one position and 4 mantissa bits, clamped to [0, 2048]
    always_comb begin
        lead = 0;
        for (int i = 0; i < SUM_W; i++) begin
            if (sum_q[i]) lead = i;
        end
        mant   = 4'((sum_q << (SUM_W - 1 - lead)) >> (SUM_W - 5));
        ln_raw = (lead - 15) * LN2_Q7 + int'(LN1P_Q7[mant]);
        if (sum_q == '0)        ln_off_d = D_CLIP;
        else if (ln_raw < 0)    ln_off_d = '0;
        else if (ln_raw > 2048) ln_off_d = D_CLIP;
        else                    ln_off_d = ln_raw[11:0];
    end

    exp_bipartite_lut u_lut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (adv),
        .d_i    (dd[10:0]),
        .zero_i (zero_w),
        .exp_o  (exp_w)
    );

    // Row datapath: counters, max/sum tracking, pipeline valid stages, done pulse
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            len_q    <= '0;
            cnt_q    <= '0;
            max_q    <= '0;
            sum_q    <= '0;
            ln_off_q <= '0;
            v1_q     <= 1'b0;
            last1_q  <= 1'b0;
            v2_q     <= 1'b0;
            last2_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (start_ok) begin
                    len_q <= len_i;
                    max_q <= {1'b1, {(IN_W-1){1'b0}}};
                    cnt_q <= '0;
                    sum_q <= '0;
                end
                ST_LOAD: if (wr_en) begin
                    cnt_q <= (cnt_q + 1'b1 == len_q) ? '0 : cnt_q + 1'b1;
                    if (!in_mask_i && ($signed(in_data_i) > max_q)) max_q <= $signed(in_data_i);
                end
                ST_EXP_ACC: begin
                    if (issue) cnt_q <= cnt_q + 1'b1;
                    if (v2_q)  sum_q <= sum_q + SUM_W'(exp_w);
                end
                ST_LN_SUM: begin
                    cnt_q    <= '0;
                    ln_off_q <= ln_off_d;
                end
                ST_NORM: if (issue) cnt_q <= cnt_q + 1'b1;
                default: ;
            endcase
            if (adv) begin
                v1_q    <= issue;
                last1_q <= issue && (cnt_q == len_q - 1'b1);
                v2_q    <= v1_q;
                last2_q <= last1_q;
            end
            done_q <= out_hs && last2_q;
        end
    end

endmodule

// File: tb/tb_softmax_stream.sv
// tb/tb_softmax_stream.sv - directed self-checking bench for softmax_stream
module tb_softmax_stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [8:0]  len_i = '0;
    logic        in_valid_i = 1'b0;
    logic [15:0] in_data_i = '0;
    logic        in_mask_i = 1'b0;
    logic        in_ready_o;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic [15:0] out_data_o;
    logic        out_last_o;
    logic        busy_o;
    logic        done_o;

    int n_cmp = 0;
    int n_err = 0;

    int sc [256];
    bit mk [256];
    int got_d [$];
    int got_l [$];
    int ref_d [$];
    int done_cnt, lat, hold_err;

    always #5 clk = ~clk;

    softmax_stream dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start_i),
        .len_i       (len_i),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .in_mask_i   (in_mask_i),
        .in_ready_o  (in_ready_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_last_o  (out_last_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    task automatic chk(input string tag, input int obs, input int exp, input int tol = 0);
        n_cmp++;
        if (obs < exp - tol || obs > exp + tol) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    function automatic int gd(input int i);
        return (i < got_d.size()) ? got_d[i] : -1;
    endfunction

    function automatic int lasts_at(input int i);
        return (i < got_l.size()) ? got_l[i] : -1;
    endfunction

    function automatic int n_lasts();
        int c = 0;
        foreach (got_l[i]) c += got_l[i];
        return c;
    endfunction

    task automatic start_and_load(input int n);
        @(negedge clk);
        start_i = 1'b1;
        len_i   = 9'(n);
        @(negedge clk);
        start_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = 16'(sc[i]);
            in_mask_i  = mk[i];
            @(negedge clk);
        end
        in_valid_i = 1'b0;
    endtask

    // called at the first negedge after the last load beat
    task automatic collect(input bit stall);
        int cyc = 1;
        int tail = -1;
        bit prev_hold = 1'b0;
        int prev_d = 0;
        bit prev_l = 1'b0;
        got_d.delete();
        got_l.delete();
        done_cnt = 0;
        lat = -1;
        hold_err = 0;
        while (cyc < 6000 && tail != 0) begin
            if (prev_hold && (!out_valid_o || int'(out_data_o) != prev_d || out_last_o != prev_l))
                hold_err++;
            if (done_o) begin
                done_cnt++;
                if (lat < 0) lat = cyc;
                if (tail < 0) tail = 4;
            end
            out_ready_i = (stall && tail < 0) ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (out_valid_o && out_ready_i) begin
                got_d.push_back(int'(out_data_o));
                got_l.push_back(int'(out_last_o));
            end
            prev_hold = out_valid_o && !out_ready_i;
            prev_d    = int'(out_data_o);
            prev_l    = out_last_o;
            @(negedge clk);
            cyc++;
            if (tail > 0) tail--;
        end
        out_ready_i = 1'b1;
    endtask

    task automatic set_row(input int n, input int val);
        for (int i = 0; i < 256; i++) begin
            sc[i] = (i < n) ? val : 0;
            mk[i] = 1'b0;
        end
    endtask

    task automatic check_uniform4(input string tag);
        chk({tag, "_count"}, got_d.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("%s_e%0d", tag, i), gd(i), 8192, 64);
        chk({tag, "_last_pos"}, lasts_at(3), 1);
        chk({tag, "_last_count"}, n_lasts(), 1);
        chk({tag, "_done_count"}, done_cnt, 1);
    endtask

    initial begin
        int found;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", int'(out_valid_o), 0);
        chk("rst_out_data", int'(out_data_o), 0);
        chk("rst_out_last", int'(out_last_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_in_ready", int'(in_ready_o), 0);
        rst_n = 1'b1;

        // len=4, all zero scores
        set_row(4, 0);
        start_and_load(4);
        collect(1'b0);
        check_uniform4("t1");
        chk("t1_latency", lat, 2 * 4 + 6);
        chk("t1_busy_after", int'(busy_o), 0);

        // len=3, one dominant score of 10.0
        set_row(3, 0);
        sc[0] = 16'h0500;
        start_and_load(3);
        collect(1'b0);
        chk("t2_count", got_d.size(), 3);
        chk("t2_e0", gd(0), 32768, 64);
        chk("t2_e1", gd(1), 0, 3);
        chk("t2_e2", gd(2), 0, 3);

        // len=4, mask {0,1,0,1}, masked element 1 holds 0x7FFF
        set_row(4, 0);
        sc[1] = 16'h7FFF;
        mk[1] = 1'b1;
        mk[3] = 1'b1;
        start_and_load(4);
        collect(1'b0);
        chk("t3_count", got_d.size(), 4);
        chk("t3_e0", gd(0), 16384, 64);
        chk("t3_e1", gd(1), 0);
        chk("t3_e2", gd(2), 16384, 64);
        chk("t3_e3", gd(3), 0);
        ref_d = got_d;
        sc[1] = 0;
        start_and_load(4);
        collect(1'b0);
        for (int i = 0; i < 4; i++) chk($sformatf("t3_mask_inv_e%0d", i), gd(i), ref_d[i]);

        // len=5, all masked
        set_row(5, 16'h0100);
        for (int i = 0; i < 5; i++) mk[i] = 1'b1;
        start_and_load(5);
        collect(1'b0);
        chk("t4_count", got_d.size(), 5);
        for (int i = 0; i < 5; i++) chk($sformatf("t4_e%0d", i), gd(i), 0);
        chk("t4_done_count", done_cnt, 1);

        // len=1
        set_row(1, 16'h0123);
        start_and_load(1);
        collect(1'b0);
        chk("t_len1_count", got_d.size(), 1);
        chk("t_len1_e0", gd(0), 32768, 64);
        chk("t_len1_last", lasts_at(0), 1);

        // len=N_MAX random, no stall then random stall
        for (int i = 0; i < 256; i++) begin
            sc[i] = int'($urandom_range(0, 2047)) - 1024;
            mk[i] = ($urandom_range(0, 3) == 0);
        end
        start_and_load(256);
        collect(1'b0);
        chk("t5_ref_count", got_d.size(), 256);
        ref_d = got_d;
        start_and_load(256);
        collect(1'b1);
        chk("t5_stall_count", got_d.size(), 256);
        for (int i = 0; i < 256; i++) chk($sformatf("t5_e%0d", i), gd(i), ref_d[i]);
        chk("t5_hold", hold_err, 0);
        chk("t5_last_pos", lasts_at(255), 1);
        chk("t5_done_count", done_cnt, 1);

        // illegal lengths are ignored
        @(negedge clk);
        start_i = 1'b1;
        len_i   = 9'd0;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        chk("len0_busy", int'(busy_o), 0);
        start_i = 1'b1;
        len_i   = 9'd257;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        chk("len257_busy", int'(busy_o), 0);

        // reset pulsed mid-NORM
        set_row(8, 0);
        start_and_load(8);
        found = 0;
        for (int c = 0; c < 100 && found == 0; c++) begin
            if (out_valid_o) found = 1;
            else @(negedge clk);
        end
        chk("rst_mid_found_norm", found, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", int'(out_valid_o), 0);
        chk("rst_mid_busy", int'(busy_o), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // following row completes
        set_row(4, 0);
        start_and_load(4);
        collect(1'b0);
        check_uniform4("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
